// File: rtl/dmem_arbiter.sv
// dmem_arbiter: arbitrates two requesters onto the byte-wide data memory and
// sequences each 16-bit access as two byte cycles, low byte first. Byte
// reads are zero- or sign-extended. Port 1 has a starvation guard.
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_valid,
  input  logic        p0_we,
  input  logic [1:0]  p0_size,
  input  logic [15:0] p0_addr,
  input  logic [15:0] p0_wdata,
  input  logic        p1_valid,
  input  logic        p1_we,
  input  logic [1:0]  p1_size,
  input  logic [15:0] p1_addr,
  input  logic [15:0] p1_wdata,
  output logic        p0_ready,
  output logic        p1_ready,
  output logic        p0_resp,
  output logic        p1_resp,
  output logic [15:0] resp_rdata,
  output logic        busy,
  output logic        mem_re,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, FIN} state_t;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_t      state;
  logic        port_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [7:0]  lo_q;
  logic [7:0]  starve_cnt;

  logic idle;
  logic force_p1;
  logic gnt0;
  logic gnt1;
  logic is_word;

  // Grant decode: port 0 has priority unless the starvation guard has tripped.
  // Reset blocks grants so nothing is acknowledged in the reset cycle.
  assign idle     = (state == IDLE) && !reset;
  assign force_p1 = (STARVE_LIMIT != 0) && (starve_cnt == LIMIT);
  assign gnt0     = idle && p0_valid && (!p1_valid || !force_p1);
  assign gnt1     = idle && p1_valid && (!p0_valid || force_p1);
  assign p0_ready = gnt0;
  assign p1_ready = gnt1;
  assign is_word  = (size_q == 2'b00);

  // Sequencer state, latched request fields, low read byte and starvation count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      port_q     <= 1'b0;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
      lo_q       <= 8'h00;
      starve_cnt <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            port_q  <= gnt1;
            we_q    <= gnt1 ? p1_we    : p0_we;
            size_q  <= gnt1 ? p1_size  : p0_size;
            addr_q  <= gnt1 ? p1_addr  : p0_addr;
            wdata_q <= gnt1 ? p1_wdata : p0_wdata;
            state   <= ACC0;
            if (gnt1)
              starve_cnt <= 8'h00;
            else if (p1_valid && starve_cnt != LIMIT)
              starve_cnt <= starve_cnt + 8'd1;
          end
        end
        ACC0: state <= is_word ? ACC1 : FIN;
        ACC1: begin
          // Read data from the ACC0 strobe arrives now: it is the low byte.
          if (!we_q) lo_q <= mem_rdata;
          state <= FIN;
        end
        FIN:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory strobes and response, decoded from state and latched fields only.
  // Forced to zero during reset so an aborted word write never reaches its
  // high byte.
  always_comb begin
    busy       = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 16'h0000;
    mem_wdata  = 8'h00;
    p0_resp    = 1'b0;
    p1_resp    = 1'b0;
    resp_rdata = 16'h0000;
    if (!reset) begin
      busy = (state != IDLE);
      case (state)
        ACC0: begin
          mem_addr = addr_q;
          if (we_q) begin
            mem_we    = 1'b1;
            mem_wdata = wdata_q[7:0];
          end else begin
            mem_re = 1'b1;
          end
        end
        ACC1: begin
          mem_addr = addr_q + 16'd1;
          if (we_q) begin
            mem_we    = 1'b1;
            mem_wdata = wdata_q[15:8];
          end else begin
            mem_re = 1'b1;
          end
        end
        FIN: begin
          p0_resp = !port_q;
          p1_resp = port_q;
          if (!we_q) begin
            if (is_word)
              resp_rdata = {mem_rdata, lo_q};
            else if (size_q == 2'b10)
              resp_rdata = {{8{mem_rdata[7]}}, mem_rdata};
            else
              resp_rdata = {8'h00, mem_rdata};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural byte memory, table of single requests,
// hand sequences for reset abort and the starvation guard. Responses are
// checked against a queue of expected {port, data, cycle} entries.
module tb_dmem_arbiter;

  localparam int LIM = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_valid, p0_we, p1_valid, p1_we;
  logic [1:0]  p0_size, p1_size;
  logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_ready, p1_ready, p0_resp, p1_resp, busy;
  logic [15:0] resp_rdata;
  logic        mem_re, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem [0:65535];

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .p0_valid(p0_valid), .p0_we(p0_we), .p0_size(p0_size), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_valid(p1_valid), .p1_we(p1_we), .p1_size(p1_size), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_ready(p0_ready), .p1_ready(p1_ready), .p0_resp(p0_resp), .p1_resp(p1_resp),
    .resp_rdata(resp_rdata), .busy(busy),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Byte memory: write on strobe, read data one cycle after mem_re.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        port;
    logic [15:0] data;
    int          rcyc;
  } exp_t;
  exp_t q[$];
  exp_t e;

  typedef struct {
    logic        port;
    logic        we;
    logic [1:0]  size;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[10];

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Response monitor: every resp pulse must match the head of the queue.
  always @(negedge clk) begin
    if (!reset && (p0_resp || p1_resp)) begin
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_resp: got p0=%0b p1=%0b data=%0h expected none", p0_resp, p1_resp, resp_rdata);
      end else begin
        e = q.pop_front();
        chk("resp_port",   32'(p1_resp), 32'(e.port));
        chk("resp_onehot", 32'(p0_resp & p1_resp), 32'd0);
        chk("resp_data",   32'(resp_rdata), 32'(e.data));
        chk("resp_cycle",  32'(cyc), 32'(e.rcyc));
      end
    end
  end

  task automatic drive(input logic port, input logic we, input logic [1:0] size,
                       input logic [15:0] addr, input logic [15:0] wdata);
    if (port) begin
      p1_valid = 1'b1; p1_we = we; p1_size = size; p1_addr = addr; p1_wdata = wdata;
    end else begin
      p0_valid = 1'b1; p0_we = we; p0_size = size; p0_addr = addr; p0_wdata = wdata;
    end
  endtask

  task automatic issue(input logic port, input logic we, input logic [1:0] size,
                       input logic [15:0] addr, input logic [15:0] wdata,
                       input logic [15:0] exp, input bit push);
    int   n;
    logic r;
    n = 0;
    @(negedge clk);
    drive(port, we, size, addr, wdata);
    #1;
    r = port ? p1_ready : p0_ready;
    while (!r && n < 20) begin
      @(negedge clk);
      #1;
      r = port ? p1_ready : p0_ready;
      n++;
    end
    chk("accept", 32'(r), 32'd1);
    if (push && r) q.push_back('{port, we ? 16'h0000 : exp, cyc + ((size == 2'b00) ? 3 : 2)});
    @(negedge clk);
    p0_valid = 1'b0;
    p1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] exp_ord;
    logic [5:0] ord;
    int         g;
    int         n;

    tbl[0] = '{1'b0, 1'b1, 2'b00, 16'h0020, 16'h1234, 16'h0000};
    tbl[1] = '{1'b0, 1'b0, 2'b00, 16'h0020, 16'h0000, 16'h1234};
    tbl[2] = '{1'b1, 1'b1, 2'b01, 16'h0030, 16'h7F80, 16'h0000};
    tbl[3] = '{1'b0, 1'b0, 2'b01, 16'h0030, 16'h0000, 16'h0080};
    tbl[4] = '{1'b0, 1'b0, 2'b10, 16'h0030, 16'h0000, 16'hFF80};
    tbl[5] = '{1'b1, 1'b0, 2'b11, 16'h0030, 16'h0000, 16'h0080};
    tbl[6] = '{1'b0, 1'b1, 2'b00, 16'hFFFF, 16'hBEEF, 16'h0000};
    tbl[7] = '{1'b1, 1'b0, 2'b00, 16'hFFFF, 16'h0000, 16'hBEEF};
    tbl[8] = '{1'b0, 1'b0, 2'b01, 16'h0000, 16'h0000, 16'h00BE};
    tbl[9] = '{1'b1, 1'b0, 2'b10, 16'h0020, 16'h0000, 16'h0034};

    p0_valid = 0; p0_we = 0; p0_size = 0; p0_addr = 0; p0_wdata = 0;
    p1_valid = 0; p1_we = 0; p1_size = 0; p1_addr = 0; p1_wdata = 0;

    // Reset: a pending request must not be acknowledged, outputs all zero.
    reset = 1'b1;
    p0_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_p0_ready", 32'(p0_ready), 32'd0);
    chk("rst_busy",     32'(busy), 32'd0);
    chk("rst_mem_strb", 32'({mem_re, mem_we}), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_resp",     32'({p0_resp, p1_resp, resp_rdata}), 32'd0);
    p0_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy",  32'(busy), 32'd0);
    chk("idle_ready", 32'({p0_ready, p1_ready}), 32'd0);
    chk("idle_mem",   32'({mem_re, mem_we, mem_addr, mem_wdata}), 32'd0);

    // Port-0 byte write, strobes one cycle after accept; a port-1 request
    // raised while busy is not accepted.
    drive(1'b0, 1'b1, 2'b01, 16'h0010, 16'h00A5);
    #1;
    chk("t1_ready", 32'(p0_ready), 32'd1);
    q.push_back('{1'b0, 16'h0000, cyc + 2});
    @(negedge clk);
    p0_valid = 1'b0;
    drive(1'b1, 1'b0, 2'b01, 16'h0010, 16'h0000);
    #1;
    chk("t1_busy_p1_ready", 32'(p1_ready), 32'd0);
    chk("t1_mem_we",    32'({mem_we, mem_re}), 32'b10);
    chk("t1_mem_addr",  32'(mem_addr), 32'h0010);
    chk("t1_mem_wdata", 32'(mem_wdata), 32'hA5);
    p1_valid = 1'b0;
    @(negedge clk);
    chk("t1_fin_mem", 32'({mem_re, mem_we}), 32'd0);
    wait_idle();
    chk("t1_mem_content", 32'(mem[16'h0010]), 32'hA5);

    // Table of single requests.
    for (int i = 0; i < 10; i++)
      issue(tbl[i].port, tbl[i].we, tbl[i].size, tbl[i].addr, tbl[i].wdata, tbl[i].exp, 1'b1);
    wait_idle();
    chk("wrap_hi_byte", 32'(mem[16'h0000]), 32'hBE);
    chk("wrap_lo_byte", 32'(mem[16'hFFFF]), 32'hEF);

    // Reset during ACC1 of a port-1 word write: only the low byte lands.
    issue(1'b0, 1'b1, 2'b00, 16'h0060, 16'h5566, 16'h0000, 1'b1);
    wait_idle();
    @(negedge clk);
    drive(1'b1, 1'b1, 2'b00, 16'h0060, 16'hAABB);
    #1;
    chk("ab_ready", 32'(p1_ready), 32'd1);
    @(negedge clk);
    p1_valid = 1'b0;
    chk("ab_acc0_wdata", 32'({mem_we, mem_wdata}), 32'h1BB);
    @(negedge clk);
    chk("ab_acc1_addr", 32'(mem_addr), 32'h0061);
    reset = 1'b1;
    #1;
    chk("ab_rst_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_no_resp", 32'({p0_resp, p1_resp}), 32'd0);
    issue(1'b1, 1'b0, 2'b00, 16'h0060, 16'h0000, 16'h55BB, 1'b1);
    wait_idle();

    // Starvation guard: both ports held valid, port 1 forced every third grant.
    issue(1'b0, 1'b1, 2'b01, 16'h0040, 16'h0011, 16'h0000, 1'b1);
    issue(1'b1, 1'b1, 2'b00, 16'h0050, 16'h2233, 16'h0000, 1'b1);
    wait_idle();
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b01, 16'h0040, 16'h0000);
    drive(1'b1, 1'b0, 2'b00, 16'h0050, 16'h0000);
    exp_ord = 6'b100100;
    ord = 6'b000000;
    g = 0;
    n = 0;
    while (g < 6 && n < 60) begin
      #1;
      if (p0_ready || p1_ready) begin
        chk("st_grant_onehot", 32'(p0_ready & p1_ready), 32'd0);
        ord[g] = p1_ready;
        q.push_back('{p1_ready, p1_ready ? 16'h2233 : 16'h0011, cyc + (p1_ready ? 3 : 2)});
        g++;
      end
      @(negedge clk);
      n++;
    end
    p0_valid = 1'b0;
    p1_valid = 1'b0;
    chk("st_grant_count", 32'(g), 32'd6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("st_order_%0d", i), 32'(ord[i]), 32'(exp_ord[i]));
    wait_idle();

    repeat (3) @(negedge clk);
    chk("final_queue_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
